// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment glyph constants and driver state type
package seg7_pkg;
  localparam logic [6:0] SEG7_GLYPH_0 = 7'h3F;
  localparam logic [6:0] SEG7_GLYPH_1 = 7'h06;
  localparam logic [6:0] SEG7_GLYPH_2 = 7'h5B;
  localparam logic [6:0] SEG7_GLYPH_3 = 7'h4F;
  localparam logic [6:0] SEG7_GLYPH_4 = 7'h66;
  localparam logic [6:0] SEG7_GLYPH_5 = 7'h6D;
  localparam logic [6:0] SEG7_GLYPH_6 = 7'h7D;
  localparam logic [6:0] SEG7_GLYPH_7 = 7'h07;
  localparam logic [6:0] SEG7_GLYPH_8 = 7'h7F;
  localparam logic [6:0] SEG7_GLYPH_9 = 7'h6F;
  localparam logic [6:0] SEG7_GLYPH_A = 7'h77;
  localparam logic [6:0] SEG7_GLYPH_B = 7'h7C;
  localparam logic [6:0] SEG7_GLYPH_C = 7'h39;
  localparam logic [6:0] SEG7_GLYPH_D = 7'h5E;
  localparam logic [6:0] SEG7_GLYPH_E = 7'h79;
  localparam logic [6:0] SEG7_GLYPH_F = 7'h71;
  localparam logic [6:0] SEG7_BLANK   = 7'h00;
  localparam logic [6:0] SEG7_TABLE [16] = '{
    SEG7_GLYPH_0, SEG7_GLYPH_1, SEG7_GLYPH_2, SEG7_GLYPH_3,
    SEG7_GLYPH_4, SEG7_GLYPH_5, SEG7_GLYPH_6, SEG7_GLYPH_7,
    SEG7_GLYPH_8, SEG7_GLYPH_9, SEG7_GLYPH_A, SEG7_GLYPH_B,
    SEG7_GLYPH_C, SEG7_GLYPH_D, SEG7_GLYPH_E, SEG7_GLYPH_F
  };
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} seg7_state_t;
endpackage

// File: rtl/seg7_glyph_decoder.sv
// seg7_glyph_decoder: 4-bit code to {g..a} segments; codes above 9 blank unless hex is enabled
module seg7_glyph_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       hex_en_i,
  output logic [6:0] seg_o
);
  assign seg_o = (code_i > 4'd9 && !hex_en_i) ? SEG7_BLANK : SEG7_TABLE[code_i];
endmodule

// File: rtl/seg7_chain_driver.sv
// seg7_chain_driver: snapshots digits into a 7-segment frame and shifts it into a daisy chain; SEG7_LEADING_ZERO_BLANK_EN adds leading-zero blanking
module seg7_chain_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SYS_CLK_HZ   = 50_000_000,
  parameter int SHIFT_CLK_HZ = 1_000_000,
  parameter int HEX_GLYPHS   = 0,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic                    i_start_stb,
  input  logic                    i_auto,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank_mask,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_serial_data,
  output logic                    o_serial_clk,
  output logic                    o_serial_latch
);
  localparam int W = 8*NUM_DIGITS;
  localparam int CLK_DIV = SYS_CLK_HZ/(2*SHIFT_CLK_HZ);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(W+1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV-1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W-1);

  if (CLK_DIV < 1 || NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_cfg
    $error("seg7_chain_driver: need CLK_DIV >= 1 and NUM_DIGITS in 1..16");
  end

  seg7_state_t state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [W-1:0] sr_q, sr_d, frame;
  logic pending_q, pending_d, reload, div_end;
  logic [NUM_DIGITS-1:0] lz;
  logic [6:0] seg [NUM_DIGITS];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic lz_run;
  // zeros from the leftmost digit down to digit 1 lose their segments until a nonzero digit
  always_comb begin
    lz = '0;
    lz_run = 1'b1;
    for (int d = NUM_DIGITS-1; d > 0; d--) begin
      lz_run = lz_run && (i_digits[4*d +: 4] == 4'd0);
      lz[d] = lz_run;
    end
  end
`else
  assign lz = '0;
`endif

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    seg7_glyph_decoder u_dec (
      .code_i  (i_digits[4*i +: 4]),
      .hex_en_i(HEX_GLYPHS != 0),
      .seg_o   (seg[i])
    );
    assign frame[8*i +: 8] = (i_en ? {i_dp[i], (i_blank_mask[i] | lz[i]) ? SEG7_BLANK : seg[i]} : 8'h00)
                           ^ {8{ACTIVE_LOW != 0}};
  end

  assign div_end = cnt_q == DIV_LAST;

  // state, divider, bit counter, pending flag and frame shift register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sr_q      <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      pending_q <= pending_d;
    end
  end

  // phase sequencing, frame reload and chain pin levels
  always_comb begin
    state_d        = state_q;
    cnt_d          = div_end ? '0 : cnt_q + 1'b1;
    bit_d          = bit_q;
    sr_d           = sr_q;
    pending_d      = pending_q | (i_start_stb & (state_q != IDLE));
    reload         = 1'b0;
    o_busy         = state_q != IDLE;
    o_done         = 1'b0;
    o_serial_data  = 1'b0;
    o_serial_clk   = 1'b0;
    o_serial_latch = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        reload = i_start_stb;
      end
      SHIFT_LO: begin
        o_serial_data = sr_q[W-1];
        state_d       = div_end ? SHIFT_HI : SHIFT_LO;
      end
      SHIFT_HI: begin
        o_serial_data = sr_q[W-1];
        o_serial_clk  = 1'b1;
        if (div_end) begin
          sr_d    = sr_q << 1;
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == BIT_LAST) ? LATCH : SHIFT_LO;
        end
      end
      LATCH: begin
        o_serial_latch = 1'b1;
        state_d        = div_end ? DONE : LATCH;
      end
      DONE: begin
        o_done    = 1'b1;
        reload    = pending_q | i_auto | i_start_stb;
        pending_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reload) begin
      sr_d    = frame;
      cnt_d   = '0;
      bit_d   = '0;
      state_d = SHIFT_LO;
    end
  end
endmodule

// File: doc/seg7_chain_driver.md
# seg7_chain_driver

Parametrised successor to the fixed six-digit clock output path. It snapshots `NUM_DIGITS` BCD/hex digits plus decimal points and converts them to 7-segment bytes. It then shifts the frame MSB-first into an external daisy-chained shift-register string and pulses the latch. It adds per-digit blanking, selectable output polarity, hex glyphs, queued start requests and an auto-refresh mode, and sits between the clock/time datapath and the display pins.

## Interface
- `NUM_DIGITS`, 6: digits in the chain, 1..16; frame width `W = 8*NUM_DIGITS`.
- `SYS_CLK_HZ`, 50_000_000: system clock frequency.
- `SHIFT_CLK_HZ`, 1_000_000: serial clock frequency.
  - `CLK_DIV = SYS_CLK_HZ/(2*SHIFT_CLK_HZ)`; must be ≥1, otherwise elaboration error.
- `HEX_GLYPHS`, 0: 1 makes codes 10..15 render A,b,C,d,E,F; 0 makes them render blank.
- `ACTIVE_LOW`, 0: 1 inverts every frame bit (common-anode displays).
- `i_clk`, in, 1: system clock, rising edge.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_en`, in, 1: 0 blanks the entire frame, including decimal points.
- `i_start_stb`, in, 1: one-cycle request to send a frame.
- `i_auto`, in, 1: 1 restarts a new frame immediately after each completed frame.
- `i_digits`, in, `4*NUM_DIGITS`: digit d at `[4d+3:4d]`; digit `NUM_DIGITS-1` is leftmost.
- `i_dp`, in, `NUM_DIGITS`: decimal point per digit.
- `i_blank_mask`, in, `NUM_DIGITS`: 1 blanks the segments of that digit (decimal point kept).
- `o_busy`, out, 1: frame in progress.
- `o_done`, out, 1: one-cycle pulse on frame completion.
- `o_serial_data`, out, 1: serial data to the chain.
- `o_serial_clk`, out, 1: serial clock to the chain.
- `o_serial_latch`, out, 1: storage-register latch to the chain.

## Operation
- Segment byte per digit is `{dp, g,f,e,d,c,b,a}`.
  - Glyphs: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Hex glyphs: A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
- Blanking applies before polarity: `i_en=0` forces 0x00; blank mask forces segments to 0 (dp kept).
- Frame is `{byte[NUM_DIGITS-1], …, byte[0]}`, then inverted if `ACTIVE_LOW`. It is shifted MSB first.
- All inputs are captured into the shift register in the cycle a start is accepted. Later input changes do not affect the frame in flight.
- States:
  - `IDLE`:
    - `o_busy=0`; all serial outputs are 0.
    - On `i_start_stb`, load the frame, clear the divider and bit counter, then go to `SHIFT_LO`.
  - `SHIFT_LO`:
    - `o_serial_clk=0`; `o_serial_data=sr[W-1]`.
    - After `CLK_DIV` cycles, go to `SHIFT_HI`.
  - `SHIFT_HI`:
    - `o_serial_clk=1`; data is held.
    - After `CLK_DIV` cycles, shift `sr` left by 1.
    - Go to `LATCH` if this was bit W-1, else go to `SHIFT_LO`.
  - `LATCH`:
    - `o_serial_latch=1`, `o_serial_clk=0`, `o_serial_data=0`.
    - After `CLK_DIV` cycles, go to `DONE`.
  - `DONE`:
    - One cycle; `o_done=1`.
    - If `pending` or `i_auto` is set, reload the frame, clear `pending` and go to `SHIFT_LO`. Otherwise go to `IDLE`.
- `pending` flag:
  - Set when `i_start_stb` is high in any non-IDLE state, including `DONE`.
  - Multiple requests collapse into one.
  - `i_start_stb` in `DONE` when `i_auto=1` does not leave `pending` set.
- Divider and bit counter are sized with `$clog2`. The bit counter wraps only via reload.

## Timing
- Reset values: all outputs 0, state `IDLE`, `pending=0`, `sr=0`.
- Reset mid-frame aborts immediately: the next cycle has all outputs 0, and no latch or done pulse is produced.
- Cycle numbering: start accepted at cycle t0.
  - First `SHIFT_LO` cycle is t0+1.
  - `o_done` is asserted at t0 + `2*CLK_DIV*W` + `CLK_DIV` + 1.
- `o_busy` = state != `IDLE`; it is high from t0+1 through the `DONE` cycle inclusive.
- A back-to-back frame begins the cycle after `DONE`, with no idle gap.
- Data changes only on the falling `o_serial_clk` phase boundary. This gives `CLK_DIV` cycles of setup and hold around each rising edge.

## Configuration
- `SEG7_LEADING_ZERO_BLANK_EN`:
  - Defined: starting from the leftmost digit, consecutive digits equal to 0 are blanked (segments only) down to, but never including, digit 0.
    - Blanking stops at the first nonzero digit.
    - A digit already blanked by mask still counts as a leading zero if its code is 0.
  - Undefined: no leading-zero logic is synthesised; zeros display as 0x3F.

## Structure
- Shared package `seg7_pkg`: glyph constants (`SEG7_GLYPH_0`..`SEG7_GLYPH_F`, `SEG7_BLANK`) and the state enum `seg7_state_t`.
- One sub-module `seg7_glyph_decoder`: 4-bit code + hex enable → 7-bit segments, purely combinational, instantiated `NUM_DIGITS` times via generate.
- The divider, FSM, pending logic and shift register live in the top module.

## Test plan
- Basic frame (`NUM_DIGITS=2`, `CLK_DIV=2`, digits=0x12, dp=2'b10, start at t0):
  - The 16 bits sampled on rising `o_serial_clk` are 0x865B.
  - Latch is high for 2 cycles.
  - `o_done` occurs at t0+67.
- Blanking and polarity:
  - `i_en=0` → 0x0000 shifted.
  - `ACTIVE_LOW=1` with digits 0x12 → 0x79A4; blank_mask=2'b01 → 0x79FF.
- Hex glyphs: digits 0xAF with `HEX_GLYPHS=0` → 0x0000; with `HEX_GLYPHS=1` → 0x7771.
- Queued and auto restart:
  - Two `i_start_stb` pulses mid-frame → exactly one extra frame, starting the cycle after `o_done`.
  - `i_auto=1` → continuous frames, each separated by exactly one `DONE` cycle.
- Reset mid-frame: assert `i_reset` at bit 5 → all outputs 0 the next cycle; no `o_done`; a subsequent start gives a normal frame.
- Macro on: 4 digits 0x0070 → bytes 0x00,0x00,0x07,0x3F. Macro off → 0x3F,0x3F,0x07,0x3F. Digits 0x0000 with macro on → 0x00,0x00,0x00,0x3F.
